// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS format codes, field widths, opcodes and loader states
package mips_isa_pkg;
  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} ld_state_t;
endpackage

// File: rtl/instr_word_loader_encoder.sv
// instr_encoder: packs decoded fields into an R/I/J instruction word
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic [OP_W-1:0]    opcode,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [FUNC_W-1:0]  func,
  input  logic [IMM_W-1:0]   imm,
  input  logic [JADDR_W-1:0] jaddr,
  output logic [31:0]        word,
  output logic               illegal
);
  always_comb begin
    word = fmt == FMT_R ? {opcode, rs, rt, rd, shamt, func} :
           fmt == FMT_I ? {opcode, rs, rt, imm} :
           fmt == FMT_J ? {opcode, jaddr} : 32'h0;
    illegal = fmt == FMT_ILL;
  end
endmodule

// File: rtl/instr_word_loader.sv
// instr_word_loader: encodes field bundles and streams them into instruction memory
module instr_word_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_func,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jaddr,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  ld_state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] word;
  logic illegal, acc, full_next;
  instr_encoder u_enc (
    .fmt(in_fmt), .opcode(in_opcode), .rs(in_rs), .rt(in_rt), .rd(in_rd),
    .shamt(in_shamt), .func(in_func), .imm(in_imm), .jaddr(in_jaddr),
    .word(word), .illegal(illegal)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // the capacity limit ends the session on the accept that fills the last word
  always_comb begin
    in_ready  = state == S_LOAD;
    busy      = state == S_LOAD;
    done      = state == S_DONE;
    acc       = in_valid && in_ready;
    full_next = !illegal && count == {1'b0, {ADDR_W{1'b1}}};
    state_n   = state;
    if (state != S_LOAD && start) state_n = S_LOAD;
    else if (acc && (in_last || full_next)) state_n = S_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= acc && !illegal;
      if (state != S_LOAD && start) begin
        ptr   <= ADDR_W'(BASE_ADDR);
        count <= '0;
        err   <= 1'b0;
      end else if (acc && illegal) begin
        err <= 1'b1;
      end else if (acc) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
        ptr       <= ptr + 1'b1;
        count     <= count + 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_word_loader.sv
// tb_instr_word_loader: randomized + directed check against a session-level model
module tb_instr_word_loader;
  localparam int AW = 2;
  localparam int BASE = 0;
  localparam int CAP = 1 << AW;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, in_last = 0;
  logic [1:0] in_fmt = 0;
  logic [5:0] in_opcode = 0, in_func = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_jaddr = 0;
  logic in_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [AW:0] count;
  int nvec = 0, nbad = 0;
  int ph = 0, mptr = 0, mcnt = 0, merr = 0, e_we = 0, e_addr = 0;
  logic [31:0] e_wdata = 0;
  instr_word_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_func(in_func), .in_imm(in_imm), .in_jaddr(in_jaddr),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] enc();
    logic [31:0] op = 32'(in_opcode) << 26;
    if (in_fmt == 2'd0)
      return op | (32'(in_rs) << 21) | (32'(in_rt) << 16) | (32'(in_rd) << 11) | (32'(in_shamt) << 6) | 32'(in_func);
    if (in_fmt == 2'd1) return op | (32'(in_rs) << 21) | (32'(in_rt) << 16) | 32'(in_imm);
    return op | 32'(in_jaddr);
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk();
    cmp("in_ready", 32'(in_ready), 32'(ph == 1));
    cmp("busy", 32'(busy), 32'(ph == 1));
    cmp("done", 32'(done), 32'(ph == 2));
    cmp("count", 32'(count), 32'(mcnt));
    cmp("err", 32'(err), 32'(merr));
    cmp("mem_we", 32'(mem_we), 32'(e_we));
    cmp("mem_addr", 32'(mem_addr), 32'(e_addr));
    cmp("mem_wdata", mem_wdata, e_wdata);
  endtask
  task automatic model();
    e_we = 0;
    if (ph == 1 && in_valid) begin
      if (in_fmt == 2'd3) merr = 1;
      else begin
        e_we = 1; e_addr = mptr; e_wdata = enc();
        mptr = (mptr + 1) % CAP; mcnt++;
      end
      if (in_last || mcnt == CAP) ph = 2;
    end else if (ph != 1 && start) begin
      ph = 1; mptr = BASE; mcnt = 0; merr = 0;
    end
  endtask
  task automatic tick();
    chk();
    model();
    @(posedge clk);
    @(negedge clk);
    start = 0; in_valid = 0; in_last = 0;
  endtask
  task automatic do_rst();
    rst = 1;
    #1;
    ph = 0; mptr = 0; mcnt = 0; merr = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    chk();
    @(negedge clk);
    rst = 0;
    start = 0; in_valid = 0; in_last = 0;
  endtask
  task automatic bun(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                     input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja, input logic l);
    in_valid = 1; in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_func = fn; in_imm = im; in_jaddr = ja; in_last = l;
  endtask
  task automatic go();
    start = 1;
    tick();
  endtask
  initial begin
    @(negedge clk);
    do_rst();
    cmp("rst_count", 32'(count), 0);
    cmp("rst_ready", 32'(in_ready), 0);
    go();
    cmp("start_busy", 32'(busy), 1);
    bun(0, 6'h00, 1, 2, 3, 0, 6'h20, 0, 0, 1);
    tick();
    cmp("add_word", mem_wdata, 32'h00221820);
    cmp("add_addr", 32'(mem_addr), BASE);
    cmp("add_done", 32'(done), 1);
    go();
    cmp("restart_count", 32'(count), 0);
    bun(1, 6'h08, 1, 2, 0, 0, 0, 16'h0005, 0, 0);
    tick();
    cmp("addi_word", mem_wdata, 32'h20220005);
    bun(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h100, 1);
    tick();
    cmp("j_word", mem_wdata, 32'h08000100);
    cmp("j_addr", 32'(mem_addr), 1);
    cmp("j_count", 32'(count), 2);
    go();
    bun(0, 6'h00, 4, 5, 6, 0, 6'h22, 0, 0, 0);
    tick();
    bun(3, 6'h3f, 7, 7, 7, 7, 6'h3f, 16'hffff, 26'h3ffffff, 0);
    tick();
    cmp("ill_we", 32'(mem_we), 0);
    cmp("ill_err", 32'(err), 1);
    bun(1, 6'h23, 3, 4, 0, 0, 0, 16'h0010, 0, 1);
    tick();
    cmp("ill_next_addr", 32'(mem_addr), 1);
    cmp("ill_count", 32'(count), 2);
    go();
    cmp("start_clears_err", 32'(err), 0);
    for (int i = 0; i < 5; i++) begin
      bun(0, 6'(i), 5'(i), 5'(i + 1), 5'(i + 2), 0, 6'h20, 0, 0, 0);
      if (i == 1) start = 1;
      tick();
      if (i == 1) cmp("start_in_load_count", 32'(count), 2);
    end
    cmp("full_we", 32'(mem_we), 0);
    cmp("full_addr", 32'(mem_addr), 3);
    cmp("full_count", 32'(count), 4);
    cmp("full_ready", 32'(in_ready), 0);
    go();
    bun(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'h2a, 0);
    tick();
    cmp("pre_rst_we", 32'(mem_we), 1);
    do_rst();
    cmp("rst_we", 32'(mem_we), 0);
    cmp("rst_wdata", mem_wdata, 0);
    go();
    bun(1, 6'h2b, 1, 1, 0, 0, 0, 16'h1234, 0, 0);
    tick();
    cmp("reload_addr", 32'(mem_addr), BASE);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) do_rst();
      else begin
        start = ($urandom_range(0, 9) == 0) || (ph != 1 && $urandom_range(0, 2) == 0);
        in_valid = $urandom_range(0, 3) != 0;
        in_fmt = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
        in_opcode = 6'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
        in_rd = 5'($urandom); in_shamt = 5'($urandom); in_func = 6'($urandom);
        in_imm = 16'($urandom); in_jaddr = 26'($urandom);
        in_last = $urandom_range(0, 5) == 0;
        tick();
      end
    end
    chk();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
